// File: rtl/cv32e40p_pkg.sv
// Shared types for the TMR fault monitor slice.
//   replica_state_e : health state of one ALU replica as tracked by the monitor
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    RS_OK      = 2'd0,
    RS_SUSPECT = 2'd1,
    RS_FAILED  = 2'd2
  } replica_state_e;

  localparam int unsigned NUM_REPLICAS = 3;

endpackage

// File: rtl/cv32e40p_replica_health.sv
// Health tracker for one ALU replica.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   valid             : a sample was classified this cycle
//   blame             : this replica was the single dissenter in that sample
//   state             : registered health state (OK / SUSPECT / FAILED)
//   life_cnt          : registered saturating lifetime blame count
//   entered_failed_c  : combinational pulse, FAILED is entered on this edge
module cv32e40p_replica_health
  import cv32e40p_pkg::*;
#(
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned GOOD_WIN   = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             blame,
  output replica_state_e   state,
  output logic [CNT_W-1:0] life_cnt,
  output logic             entered_failed_c
);

  localparam int unsigned ERR_W  = $clog2(ERR_THRESH + 1);
  localparam int unsigned GOOD_W = $clog2(GOOD_WIN + 1);
  localparam logic [CNT_W-1:0] LIFE_MAX = '1;

  replica_state_e    state_q, state_d;
  logic [ERR_W-1:0]  err_q, err_d, err_inc;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic [CNT_W-1:0]  life_q, life_d;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RS_OK;
      err_q   <= '0;
      good_q  <= '0;
      life_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      good_q  <= good_d;
      life_q  <= life_d;
    end
  end

  // Next-state: blames escalate, runs of clean samples de-escalate, FAILED is terminal
  always_comb begin
    state_d          = state_q;
    err_d            = err_q;
    good_d           = good_q;
    life_d           = life_q;
    entered_failed_c = 1'b0;
    err_inc          = err_q + ERR_W'(1);
    good_inc         = good_q + GOOD_W'(1);

    // Lifetime count keeps running even once FAILED
    if (valid && blame && (life_q != LIFE_MAX)) begin
      life_d = life_q + CNT_W'(1);
    end

    if (valid) begin
      unique case (state_q)
        RS_OK: begin
          if (blame) begin
            state_d = RS_SUSPECT;
            err_d   = ERR_W'(1);
            good_d  = '0;
          end
        end
        RS_SUSPECT: begin
          if (blame) begin
            good_d = '0;
            err_d  = err_inc;
            if (err_inc == ERR_W'(ERR_THRESH)) begin
              state_d          = RS_FAILED;
              entered_failed_c = 1'b1;
            end
          end else if (good_inc == GOOD_W'(GOOD_WIN)) begin
            state_d = RS_OK;
            err_d   = '0;
            good_d  = '0;
          end else begin
            good_d = good_inc;
          end
        end
        RS_FAILED: ;
        default: begin
          state_d = RS_OK;
          err_d   = '0;
          good_d  = '0;
        end
      endcase
    end
  end

  assign state    = state_q;
  assign life_cnt = life_q;

endmodule

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// Observation-only fault monitor for the triplicated ALU. Classifies each
// accepted sample of the three replicas, tracks per-replica health and raises
// sticky reporting bits toward debug/CSR.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   valid_i                  : sample strobe (ALU output consumed)
//   res0_i..res2_i           : replica results
//   flag0_i..flag2_i         : {comparison_result, ready} per replica
//   alarm_ack_i              : clears alarm_o, syndrome_o, uncorr_o
//   cnt_sel_i                : lifetime-counter readback select (3 reads zero)
//   mismatch_o               : pulse, previous valid sample had a disagreement
//   syndrome_o / uncorr_o    : sticky dissenter bits / sticky all-differ
//   fail_o / suspect_o       : per-replica health levels
//   alarm_o                  : sticky alarm
//   cnt_o                    : selected lifetime counter (mux of registers)
module cv32e40p_tmr_fault_monitor
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NBIT       = 32,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned GOOD_WIN   = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [NBIT-1:0]  res0_i,
  input  logic [NBIT-1:0]  res1_i,
  input  logic [NBIT-1:0]  res2_i,
  input  logic [1:0]       flag0_i,
  input  logic [1:0]       flag1_i,
  input  logic [1:0]       flag2_i,
  input  logic             alarm_ack_i,
  input  logic [1:0]       cnt_sel_i,
  output logic             mismatch_o,
  output logic [2:0]       syndrome_o,
  output logic             uncorr_o,
  output logic [2:0]       fail_o,
  output logic [2:0]       suspect_o,
  output logic             alarm_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned WORD_W = NBIT + 2;

  logic [WORD_W-1:0] w0, w1, w2;
  logic              eq01, eq02, eq12;
  logic              all_eq_c, uncorr_c;
  logic [2:0]        blame_c;
  logic [2:0]        entered_failed_c;

  replica_state_e    rep_state [NUM_REPLICAS];
  logic [CNT_W-1:0]  life_cnt  [NUM_REPLICAS];

  // Majority classifier: a replica is blamed only if the other two agree
  assign w0 = {flag0_i, res0_i};
  assign w1 = {flag1_i, res1_i};
  assign w2 = {flag2_i, res2_i};

  always_comb begin
    eq01       = (w0 == w1);
    eq02       = (w0 == w2);
    eq12       = (w1 == w2);
    all_eq_c   = eq01 && eq12;
    uncorr_c   = valid_i && !eq01 && !eq02 && !eq12;
    blame_c[0] = valid_i && eq12 && !eq01;
    blame_c[1] = valid_i && eq02 && !eq01;
    blame_c[2] = valid_i && eq01 && !eq02;
  end

  for (genvar g = 0; g < NUM_REPLICAS; g++) begin : g_health
    cv32e40p_replica_health #(
      .ERR_THRESH (ERR_THRESH),
      .GOOD_WIN   (GOOD_WIN),
      .CNT_W      (CNT_W)
    ) u_health (
      .clk              (clk),
      .rst              (rst),
      .valid            (valid_i),
      .blame            (blame_c[g]),
      .state            (rep_state[g]),
      .life_cnt         (life_cnt[g]),
      .entered_failed_c (entered_failed_c[g])
    );
  end

  // Sticky reporting; a set event in the ack cycle takes precedence over the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_o <= 1'b0;
      syndrome_o <= '0;
      uncorr_o   <= 1'b0;
      alarm_o    <= 1'b0;
    end else begin
      mismatch_o <= valid_i && !all_eq_c;
      syndrome_o <= (alarm_ack_i ? 3'b000 : syndrome_o) | blame_c;
      uncorr_o   <= (alarm_ack_i ? 1'b0 : uncorr_o) | uncorr_c;
      alarm_o    <= (alarm_ack_i ? 1'b0 : alarm_o) | uncorr_c | (|entered_failed_c);
    end
  end

  // Health levels are direct decodes of the per-replica state registers
  always_comb begin
    fail_o    = '0;
    suspect_o = '0;
    for (int k = 0; k < NUM_REPLICAS; k++) begin
      fail_o[k]    = (rep_state[k] == RS_FAILED);
      suspect_o[k] = (rep_state[k] == RS_SUSPECT);
    end
  end

  // Lifetime counter readback
  always_comb begin
    cnt_o = '0;
    unique case (cnt_sel_i)
      2'd0:    cnt_o = life_cnt[0];
      2'd1:    cnt_o = life_cnt[1];
      2'd2:    cnt_o = life_cnt[2];
      default: cnt_o = '0;
    endcase
  end

endmodule
